ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port synchronous program/data RAM (16-bit words, 8-bit address) between two requesters.
  - Requester F: CPU instruction-fetch unit, read-only.
  - Requester D: ACC load/store/IO datapath, read/write.
- Round-robin arbitration, registered RAM command outputs, registered read-data return per requester.
- Sits between the CPU core and the RAM; the RAM is its only slave.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; f_addr stable while high.
- f_addr  in  ADDR_W  fetch address.
- f_gnt  out  1  one-cycle pulse: fetch request accepted.
- f_rvalid  out  1  one-cycle pulse: f_rdata updated.
- f_rdata  out  DATA_W  last fetched word; held between updates.
- d_req  in  1  data request; d_we/d_addr/d_wdata stable while high.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data or write ack.
- d_rdata  out  DATA_W  last data-port word; held between updates.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_din  out  DATA_W  RAM write data, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_dout  in  DATA_W  RAM read data; valid the cycle after the RAM samples addr.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All gnt/rvalid/ram_we = 0.
  - ram_addr, ram_din, f_rdata, d_rdata = 0.
  - last_winner = D, so F wins the first tie.
- Clock and reset: one clock domain. Reset asserts asynchronously and is released synchronously by the surrounding reset logic.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, at edge E0:
  - No request: stay in IDLE.
  - Exactly one request: that requester wins.
  - Both requesting: the requester that is not last_winner wins.
  - On a win: register ram_addr, ram_we, and ram_din (F: ram_we=0, ram_din unchanged); set winner gnt=1; update last_winner; go to ISSUE.
- ISSUE, cycle after E0:
  - gnt and ram_we are high for this cycle only.
  - The RAM samples at edge E1.
  - At E1: gnt=0, ram_we=0, go to RESP.
- RESP, edge E2:
  - Capture ram_dout into the winner's rdata.
  - Set winner rvalid=1 for one cycle.
  - Go to IDLE.
  - For a write, the captured value equals the written word, because the RAM updates dout with din on a write.
- Latency: req sampled at E0 → rvalid high in the cycle after E2, i.e. 3 cycles from acceptance.
  - Maximum throughput is one access per 3 cycles.
  - The rvalid cycle coincides with IDLE, so a back-to-back request sampled at the end of that cycle is accepted.
- Handshake:
  - A requester keeps req and its command stable until it observes gnt at a rising edge.
  - It deasserts req, or presents a new command, no later than the cycle after gnt.
  - req is ignored in ISSUE and RESP, so holding req through gnt never causes a double issue.
- The loser of a tie keeps req asserted and is guaranteed to win the next IDLE arbitration. Starvation bound is one access.
- The non-winning rdata/rvalid never change.
- ram_addr and ram_din hold their last values outside ISSUE. The RAM's idle reads are harmless.
- Reset mid-operation:
  - ram_we drops immediately and the pending access is abandoned.
  - No rvalid is produced for it.
  - A write whose E1 edge already occurred has completed in the RAM.
- Address arithmetic: none. Addresses pass through unchanged; 0xFF is a normal address with no wrap logic.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: when both request, F always wins. last_winner is not used, and D can starve while F requests continuously.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then F reads addr 0x00 (RAM holds 0xA006) → f_gnt pulse 1 cycle after the sampling edge; f_rvalid with f_rdata=0xA006 3 cycles after acceptance; d_* unchanged.
- D writes 0x1234 to 0x07, then D reads 0x07 → write: ram_we high exactly 1 cycle, d_rvalid with d_rdata=0x1234. Read: d_rdata=0x1234.
- F and D both held high continuously from reset, F at 0x02 and D at 0x06 → grants alternate F, D, F, D. Each access completes 3 cycles apart, and every f_rdata/d_rdata matches its own address.
- Same stimulus built with RAM_ARB_FIXED_PRIO_EN → only F granted while f_req is high; D is granted on the first IDLE after f_req drops.
- reset_n pulsed low during ISSUE of a D write to 0x0A → ram_we and d_gnt drop asynchronously; no d_rvalid; FSM in IDLE; next F read at 0x0A returns the pre-existing contents.
- Single requester F holds req for 4 back-to-back reads at 0x08, 0x09, 0x0A, 0x0B (address changed after each gnt) → 4 f_rvalid pulses spaced exactly 3 cycles apart with the correct data.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one single-port RAM between fetch (F) and data (D) requesters
// Optional build macro RAM_ARB_FIXED_PRIO_EN: F always wins a tie instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              win_d_q, win_d_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              f_gnt_q, f_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

  // D wins when alone, or on a tie when F was the previous winner.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick_d = d_req && !f_req;
`else
    pick_d = d_req && (!f_req || !last_d_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    win_d_d    = win_d_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    f_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    f_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          win_d_d  = pick_d;
          last_d_d = pick_d;
          state_d  = ISSUE;
          if (pick_d) begin
            ram_addr_d = d_addr;
            ram_din_d  = d_wdata;
            ram_we_d   = d_we;
            d_gnt_d    = 1'b1;
          end else begin
            ram_addr_d = f_addr;
            f_gnt_d    = 1'b1;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        // RAM dout now reflects the address sampled at the end of ISSUE.
        if (win_d_q) begin
          d_rdata_d  = ram_dout;
          d_rvalid_d = 1'b1;
        end else begin
          f_rdata_d  = ram_dout;
          f_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b1;
      win_d_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      win_d_q    <= win_d_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      f_gnt_q    <= f_gnt_d;
      d_gnt_q    <= d_gnt_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_gnt    = f_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM and access-slot reference model
module tb_ram_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int GNT_BOUND = 4000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        f_req, d_req, d_we;
  logic [7:0]  f_addr, d_addr;
  logic [15:0] d_wdata;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, ram_we;
  logic [15:0] f_rdata, d_rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  int vectors = 0;
  int miscompares = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return 16'hA006 ^ {a, a};
  endfunction

  // Behavioural single-port RAM: a write also drives dout with the written word.
  logic [15:0] mem [256];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access occupies the RAM for three cycles (grant, response, result);
  // the shadow memory is updated when the RAM actually takes the write.
  logic [15:0] shadow [256];
  logic [15:0] fq[$];
  logic [15:0] dq[$];
  int          slot;
  bit          last_d, pend_d, pend_we;
  logic [7:0]  pend_addr;
  logic [15:0] pend_wdata;
  bit          exp_f_gnt, exp_d_gnt, exp_f_rv, exp_d_rv, exp_we;
  logic [7:0]  exp_addr;
  logic [15:0] exp_din;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot = 0; last_d = 1'b1;
      exp_f_gnt = 0; exp_d_gnt = 0; exp_f_rv = 0; exp_d_rv = 0; exp_we = 0;
      fq.delete(); dq.delete();
    end else begin
      exp_f_gnt = 0; exp_d_gnt = 0; exp_f_rv = 0; exp_d_rv = 0; exp_we = 0;
      if (slot == 2) begin
        if (pend_we) shadow[pend_addr] = pend_wdata;
        slot = 1;
      end else if (slot == 1) begin
        if (pend_d) exp_d_rv = 1; else exp_f_rv = 1;
        slot = 0;
      end else if (f_req || d_req) begin
        pend_d  = d_req && (!f_req || (!FIXED && !last_d));
        last_d  = pend_d;
        pend_we = pend_d && d_we;
        pend_addr  = pend_d ? d_addr : f_addr;
        pend_wdata = d_wdata;
        if (pend_d) dq.push_back(d_we ? d_wdata : shadow[d_addr]);
        else        fq.push_back(shadow[f_addr]);
        exp_f_gnt = !pend_d;
        exp_d_gnt = pend_d;
        exp_we    = pend_we;
        exp_addr  = pend_addr;
        exp_din   = pend_wdata;
        slot = 2;
      end
    end
  end

  logic [15:0] last_f_rd, last_d_rd;
  always @(negedge clock) begin
    if (!reset_n) begin
      last_f_rd = 16'h0; last_d_rd = 16'h0;
    end else begin
      chk("f_gnt", f_gnt, exp_f_gnt);
      chk("d_gnt", d_gnt, exp_d_gnt);
      chk("ram_we", ram_we, exp_we);
      chk("f_rvalid", f_rvalid, exp_f_rv);
      chk("d_rvalid", d_rvalid, exp_d_rv);
      if (exp_f_gnt || exp_d_gnt) begin
        chk("ram_addr", ram_addr, exp_addr);
        if (exp_we) chk("ram_din", ram_din, exp_din);
      end
      if (f_rvalid && exp_f_rv && fq.size() > 0) chk("f_rdata", f_rdata, fq.pop_front());
      else if (!f_rvalid) chk("f_rdata_hold", f_rdata, last_f_rd);
      if (d_rvalid && exp_d_rv && dq.size() > 0) chk("d_rdata", d_rdata, dq.pop_front());
      else if (!d_rvalid) chk("d_rdata_hold", d_rdata, last_d_rd);
      last_f_rd = f_rdata;
      last_d_rd = d_rdata;
    end
  end

  task automatic wait_gnt(input bit is_d);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(is_d ? d_gnt : f_gnt) && n < GNT_BOUND);
    if (n >= GNT_BOUND) chk(is_d ? "d_gnt_timeout" : "f_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic f_issue(input logic [7:0] a, input int gap);
    f_addr = a;
    f_req  = 1'b1;
    wait_gnt(1'b0);
    @(posedge clock); #1;
    if (gap > 0) begin
      f_req = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic d_issue(input logic we, input logic [7:0] a, input logic [15:0] wd, input int gap);
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    wait_gnt(1'b1);
    @(posedge clock); #1;
    if (gap > 0) begin
      d_req = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic f_rand(input int n);
    for (int i = 0; i < n; i++)
      f_issue((i % 17 == 0) ? 8'hFF : 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    f_req = 1'b0;
  endtask

  task automatic d_rand(input int n);
    for (int i = 0; i < n; i++)
      d_issue(1'($urandom), (i % 13 == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
              16'($urandom), $urandom_range(0, 3));
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = init_val(8'(i));
      shadow[i] = init_val(8'(i));
    end
    reset_n = 1'b0; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_f_gnt", f_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
    chk("rst_f_rvalid", f_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_ram_we", ram_we, 0);     chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);   chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // single fetch of address 0
    f_issue(8'h00, 0); f_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("t1_f_rdata", f_rdata, 16'hA006);
    chk("t1_d_rdata", d_rdata, 16'h0);

    // data write then read-back
    d_issue(1'b1, 8'h07, 16'h1234, 0); d_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("t2_wr_ack", d_rdata, 16'h1234);
    d_issue(1'b0, 8'h07, 16'h0000, 0); d_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("t2_rd", d_rdata, 16'h1234);

    // both requesters held from reset
    reset_n = 1'b0;
    fork
      begin for (int i = 0; i < 4; i++) f_issue(8'h02, 0); f_req = 1'b0; end
      begin for (int i = 0; i < 4; i++) d_issue(1'b0, 8'h06, 16'h0, 0); d_req = 1'b0; end
      begin repeat (2) @(posedge clock); #1 reset_n = 1'b1; end
    join
    repeat (4) @(posedge clock); #1;
    chk("t3_f_rdata", f_rdata, init_val(8'h02));
    chk("t3_d_rdata", d_rdata, init_val(8'h06));

    // reset during the issue cycle of a data write abandons it
    d_we = 1'b1; d_addr = 8'h0A; d_wdata = 16'hBEEF; d_req = 1'b1;
    wait_gnt(1'b1);
    reset_n = 1'b0; d_req = 1'b0;
    #1;
    chk("abort_ram_we", ram_we, 0);
    chk("abort_d_gnt", d_gnt, 0);
    chk("abort_d_rvalid", d_rvalid, 0);
    repeat (2) @(posedge clock); #1 reset_n = 1'b1;
    f_issue(8'h0A, 0); f_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("abort_f_rdata", f_rdata, init_val(8'h0A));

    // back-to-back fetches from one requester
    for (int i = 0; i < 4; i++) f_issue(8'(8 + i), 0);
    f_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("t6_last_rdata", f_rdata, init_val(8'h0B));

    // randomized contention
    fork
      f_rand(150);
      d_rand(150);
    join
    repeat (5) @(posedge clock); #1;
    chk("fq_drained", fq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
